alu_shift_sequencer: RTL and testbench
======================================

// Module: alu_shift_sequencer
// PURPOSE
//  Multi-cycle controller for the 32-bit ALU operation set (000 OR, 001 ADD, 010 SLL).
//  Latches operands on a start handshake, then runs OR/ADD in one step.
//  Runs SLL as one shift per clock under a down-counter; no combinational shift loop.
//  Sits between decode/control and the writeback mux; produces result plus zero/negative flags.
// PARAMETERS
//  WIDTH   32  datapath width of a, b, result
//  SHW     5   shift-count width; must equal log2(WIDTH)
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      synchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  op       in   3      ALU control line: 000 OR, 001 ADD, 010 SLL, others illegal
//  a        in   WIDTH  operand A (shift source for SLL)
//  b        in   WIDTH  operand B (shift amount for SLL)
//  busy     out  1      high whenever state != IDLE
//  done     out  1      one-cycle pulse: result/flags/err valid and updated
//  result   out  WIDTH  registered result; holds until next accepted op completes
//  zflag    out  1      registered: result == 0
//  nflag    out  1      registered: result[WIDTH-1]
//  err      out  1      registered: last completed op was illegal
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, zflag=1, nflag=0, err=0; counter=0.
//   Reset wins over every other event; reset mid-op aborts with no done pulse.
//  States: IDLE, EXEC, SHIFT, DONE.
//  IDLE: on start=1 at edge T0, latch op, a, b ("accept"); start=0 stays IDLE.
//   SLL with b < WIDTH goes to SHIFT: acc=a, cnt=b[SHW-1:0].
//   All other ops (OR, ADD, illegal, SLL with b >= WIDTH) go to EXEC.
//  EXEC: next edge computes into result and goes to DONE.
//   OR = a|b; ADD = a+b mod 2^WIDTH, carry discarded.
//   SLL with b >= WIDTH = 0; illegal op = 0 with err=1.
//  SHIFT: each edge with cnt != 0 does acc = acc << 1 (zero fill), cnt = cnt - 1.
//   Edge with cnt == 0: result = acc, go to DONE.
//  DONE: done=1 for exactly this one cycle, then IDLE on next edge.
//   start during DONE is ignored; requester re-asserts in IDLE.
//  zflag/nflag/err update on the same edge as result, never otherwise.
//   err is cleared by every legal completion.
//  Latency, accept edge T0 to done high: 1 + k edges (k = shift amount for in-range SLL,
//   else k = 0). Minimum request-to-request interval = k + 3 cycles.
//  start while busy: ignored, no queuing. op/a/b changes after accept: no effect.
//  SLL amount 0: result = a after 1 edge; amount WIDTH-1: WIDTH edges.
// TESTING
//  OR a=0x0000_F0F0, b=0x0F0F_0000 -> done 2nd cycle after accept; result 0x0F0F_F0F0, z=0, n=0.
//  ADD a=0xFFFF_FFFF, b=1 -> result 0, zflag=1, nflag=0, err=0; carry discarded.
//  SLL a=1, b=31 -> done after 32 edges; result 0x8000_0000, nflag=1; busy high throughout.
//  SLL a=0x1234, b=0 -> result 0x1234 after 1 edge.
//   SLL a=5, b=32 -> result 0, zflag=1 after 1 edge.
//  op=3'b111 -> result 0, err=1.
//   Next ADD 2+3 -> result 5, err=0; start pulsed during busy/DONE is ignored.
//  reset mid-SLL (b=20, 5 edges in) -> IDLE, all outputs at reset values, no done pulse.
//   Fresh OR is accepted next cycle.

Source files
------------

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer
//   Multi-cycle controller for the OR / ADD / SLL ALU operation set.
//   Operands are latched on an accepted start. OR and ADD complete in one
//   execute step. SLL shifts one bit per clock under a down-counter, so there
//   is no wide combinational shifter. The result and the zero/negative/error
//   flags are registered and hold until the next completion.
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request, sampled only in IDLE
//   op      in   3      000 OR, 001 ADD, 010 SLL, others illegal
//   a       in   WIDTH  operand A (shift source for SLL)
//   b       in   WIDTH  operand B (shift amount for SLL)
//   busy    out  1      high whenever not IDLE
//   done    out  1      one-cycle pulse when result/flags/err are updated
//   result  out  WIDTH  registered result
//   zflag   out  1      result == 0
//   nflag   out  1      result MSB
//   err     out  1      last completed op was illegal
module alu_shift_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zflag,
  output logic             nflag,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zflag_q, zflag_d;
  logic             nflag_q, nflag_d;
  logic             err_q, err_d;

  // SLL amounts that fit in SHW bits go through the shift loop; larger
  // amounts are resolved to zero in a single execute step.
  logic             sll_in_range;
  logic             complete;
  logic [WIDTH-1:0] res_val;
  logic             res_err;

  assign sll_in_range = (op == OP_SLL) && (b[WIDTH-1:SHW] == '0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zflag_q  <= 1'b1;
      nflag_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zflag_q  <= zflag_d;
      nflag_q  <= nflag_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = sll_in_range ? S_SHIFT : S_EXEC;
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shift loop, completion
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zflag_d  = zflag_q;
    nflag_d  = nflag_q;
    err_d    = err_q;
    complete = 1'b0;
    res_val  = '0;
    res_err  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (sll_in_range) begin
            cnt_d = b[SHW-1:0];
          end
        end
      end
      S_EXEC: begin
        complete = 1'b1;
        unique case (op_q)
          OP_OR:   res_val = a_q | b_q;
          OP_ADD:  res_val = a_q + b_q;
          OP_SLL:  res_val = '0;
          default: begin
            res_val = '0;
            res_err = 1'b1;
          end
        endcase
      end
      S_SHIFT: begin
        // a_q doubles as the shift accumulator
        if (cnt_q != '0) begin
          a_d   = {a_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - SHW'(1);
        end else begin
          complete = 1'b1;
          res_val  = a_q;
        end
      end
      default: ;
    endcase

    if (complete) begin
      result_d = res_val;
      zflag_d  = (res_val == '0);
      nflag_d  = res_val[WIDTH-1];
      err_d    = res_err;
    end
  end

  // Outputs
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    result = result_q;
    zflag  = zflag_q;
    nflag  = nflag_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
module tb_alu_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zflag;
  logic        nflag;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  alu_shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zflag  (zflag),
    .nflag  (nflag),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Present a request; returns 1 ns after the accept edge with start dropped.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    op    = o;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded); also report whether busy
  // stayed high on every sampled cycle.
  task automatic wait_done(output int edges, output bit timed_out, output bit busy_all);
    edges     = 0;
    timed_out = 1'b1;
    busy_all  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (!busy) busy_all = 1'b0;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h exp 0", result); end
    vectors++; if (zflag !== 1'b1) begin miscompares++; $display("FAIL reset_zflag got %b exp 1", zflag); end
    vectors++; if (nflag !== 1'b0) begin miscompares++; $display("FAIL reset_nflag got %b exp 0", nflag); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_or();
    int e; bit to; bit ba;
    issue(3'b000, 32'h0000_F0F0, 32'h0F0F_0000);
    wait_done(e, to, ba);
    vectors++; if (to || e != 1) begin miscompares++; $display("FAIL or_latency got %0d timeout=%0b exp 1", e, to); end
    vectors++; if (result !== 32'h0F0F_F0F0) begin miscompares++; $display("FAIL or_result got %h exp 0f0ff0f0", result); end
    vectors++; if (zflag !== 1'b0 || nflag !== 1'b0) begin miscompares++; $display("FAIL or_flags got z=%b n=%b exp z=0 n=0", zflag, nflag); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL or_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_add_wrap();
    int e; bit to; bit ba;
    issue(3'b001, 32'hFFFF_FFFF, 32'h1);
    wait_done(e, to, ba);
    vectors++; if (to || e != 1) begin miscompares++; $display("FAIL add_latency got %0d timeout=%0b exp 1", e, to); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL add_result got %h exp 0", result); end
    vectors++; if (zflag !== 1'b1 || nflag !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL add_flags got z=%b n=%b e=%b exp 1 0 0", zflag, nflag, err); end
    @(posedge clk); #1;
  endtask

  task automatic test_sll();
    int e; bit to; bit ba;
    issue(3'b010, 32'h1, 32'd31);
    wait_done(e, to, ba);
    vectors++; if (to || e != 32) begin miscompares++; $display("FAIL sll31_latency got %0d timeout=%0b exp 32", e, to); end
    vectors++; if (result !== 32'h8000_0000) begin miscompares++; $display("FAIL sll31_result got %h exp 80000000", result); end
    vectors++; if (nflag !== 1'b1 || zflag !== 1'b0) begin miscompares++; $display("FAIL sll31_flags got n=%b z=%b exp 1 0", nflag, zflag); end
    vectors++; if (!ba) begin miscompares++; $display("FAIL sll31_busy got low exp high throughout"); end
    @(posedge clk); #1;

    issue(3'b010, 32'h1234, 32'd0);
    wait_done(e, to, ba);
    vectors++; if (to || e != 1) begin miscompares++; $display("FAIL sll0_latency got %0d timeout=%0b exp 1", e, to); end
    vectors++; if (result !== 32'h1234) begin miscompares++; $display("FAIL sll0_result got %h exp 1234", result); end
    @(posedge clk); #1;

    issue(3'b010, 32'h5, 32'd32);
    wait_done(e, to, ba);
    vectors++; if (to || e != 1) begin miscompares++; $display("FAIL sll32_latency got %0d timeout=%0b exp 1", e, to); end
    vectors++; if (result !== 32'h0 || zflag !== 1'b1) begin miscompares++; $display("FAIL sll32_result got %h z=%b exp 0 z=1", result, zflag); end
    @(posedge clk); #1;

    issue(3'b010, 32'h3, 32'd4);
    wait_done(e, to, ba);
    vectors++; if (to || e != 5) begin miscompares++; $display("FAIL sll4_latency got %0d timeout=%0b exp 5", e, to); end
    vectors++; if (result !== 32'h30) begin miscompares++; $display("FAIL sll4_result got %h exp 30", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int e; bit to; bit ba;
    issue(3'b111, 32'hDEAD_BEEF, 32'h1);
    wait_done(e, to, ba);
    vectors++; if (to || e != 1) begin miscompares++; $display("FAIL ill_latency got %0d timeout=%0b exp 1", e, to); end
    vectors++; if (result !== 32'h0 || err !== 1'b1 || zflag !== 1'b1) begin miscompares++; $display("FAIL ill_result got %h err=%b z=%b exp 0 1 1", result, err, zflag); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int e; bit to; bit ba;
    issue(3'b001, 32'd2, 32'd3);
    // Hold start with different operands while busy and through DONE
    start = 1'b1;
    op    = 3'b000;
    a     = 32'hFFFF_0000;
    b     = 32'h0000_FFFF;
    wait_done(e, to, ba);
    vectors++; if (to || e != 1) begin miscompares++; $display("FAIL b2b_latency got %0d timeout=%0b exp 1", e, to); end
    vectors++; if (result !== 32'd5 || err !== 1'b0) begin miscompares++; $display("FAIL b2b_result got %h err=%b exp 5 0", result, err); end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_start_in_done got busy=%b exp 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0 || result !== 32'd5) begin miscompares++; $display("FAIL b2b_no_queue got busy=%b result=%h exp 0 5", busy, result); end
  endtask

  task automatic test_reset_mid_op();
    int e; bit to; bit ba; bit saw_done;
    saw_done = 1'b0;
    issue(3'b010, 32'h1, 32'd20);
    repeat (4) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    reset = 1'b0;
    vectors++; if (saw_done) begin miscompares++; $display("FAIL rst_mid_done got pulse exp none"); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ctrl got busy=%b done=%b exp 0 0", busy, done); end
    vectors++; if (result !== 32'h0 || zflag !== 1'b1 || nflag !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_outs got %h z=%b n=%b e=%b exp 0 1 0 0", result, zflag, nflag, err); end
    issue(3'b000, 32'hA000_0000, 32'h0000_000A);
    wait_done(e, to, ba);
    vectors++; if (to || e != 1) begin miscompares++; $display("FAIL rst_mid_fresh_latency got %0d timeout=%0b exp 1", e, to); end
    vectors++; if (result !== 32'hA000_000A || nflag !== 1'b1) begin miscompares++; $display("FAIL rst_mid_fresh_result got %h n=%b exp a000000a 1", result, nflag); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_or();
    test_add_wrap();
    test_sll();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
